// File: rtl/alu_muldiv_seq.sv
// Multi-cycle execute-stage ALU: single-cycle MIPS R-type ops plus iterative
// multu/divu into HI/LO under a start/busy/done handshake.
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       ALU_op,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Output,
  output logic             Zero_Flag,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT,
    OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_BAD
  } op_t;

  state_t             state, state_next;
  op_t                op;
  logic [2*WIDTH-1:0] p, p_next;
  logic [WIDTH-1:0]   m, m_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [WIDTH-1:0]   out_next, hi_next, lo_next, res;
  logic               zf_next, done_next;
  logic [WIDTH:0]     mul_sum, div_rem, div_sub;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_new, q_new;

  assign busy = (state != S_IDLE);

  always_comb begin
    op = OP_BAD;
    case (ALU_op)
      2'b01: op = OP_SUB;
      2'b10: begin
        case (FuncCode)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b011001: op = OP_MULTU;
          6'b011011: op = OP_DIVU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
          default:   op = OP_BAD;
        endcase
      end
      default: op = OP_ADD;
    endcase
  end

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = A + B;
      OP_SUB:  res = A - B;
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_NOR:  res = ~(A | B);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MFHI: res = HI;
      OP_MFLO: res = LO;
      default: res = '0;
    endcase
  end

  // p holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    state_next = state;
    p_next     = p;
    m_next     = m;
    cnt_next   = cnt;
    out_next   = Output;
    zf_next    = Zero_Flag;
    hi_next    = HI;
    lo_next    = LO;
    done_next  = 1'b0;
    mul_sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
    div_rem    = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_ge     = (div_rem >= {1'b0, m});
    div_sub    = div_rem - {1'b0, m};
    rem_new    = div_ge ? div_sub[WIDTH-1:0] : div_rem[WIDTH-1:0];
    q_new      = {p[WIDTH-2:0], div_ge};
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULTU: begin
              p_next     = {{WIDTH{1'b0}}, B};
              m_next     = A;
              cnt_next   = '0;
              state_next = S_MUL;
            end
            OP_DIVU: begin
              if (B == '0) begin
                lo_next   = '1;
                hi_next   = A;
                out_next  = '1;
                zf_next   = 1'b0;
                done_next = 1'b1;
              end else begin
                p_next     = {{WIDTH{1'b0}}, A};
                m_next     = B;
                cnt_next   = '0;
                state_next = S_DIV;
              end
            end
            default: begin
              out_next  = res;
              zf_next   = (res == '0);
              done_next = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        p_next   = {mul_sum, p[WIDTH-1:1]};
        cnt_next = cnt + CW'(1);
        if (cnt == LAST) begin
          hi_next    = mul_sum[WIDTH:1];
          lo_next    = {mul_sum[0], p[WIDTH-1:1]};
          out_next   = {mul_sum[0], p[WIDTH-1:1]};
          zf_next    = ({mul_sum[0], p[WIDTH-1:1]} == '0);
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DIV: begin
        p_next   = {rem_new, q_new};
        cnt_next = cnt + CW'(1);
        if (cnt == LAST) begin
          hi_next    = rem_new;
          lo_next    = q_new;
          out_next   = q_new;
          zf_next    = (q_new == '0);
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      p         <= '0;
      m         <= '0;
      cnt       <= '0;
      Output    <= '0;
      Zero_Flag <= 1'b1;
      HI        <= '0;
      LO        <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      p         <= p_next;
      m         <= m_next;
      cnt       <= cnt_next;
      Output    <= out_next;
      Zero_Flag <= zf_next;
      HI        <= hi_next;
      LO        <= lo_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq against an arithmetic
// reference model of the ALU, multu/divu and HI/LO.
module tb_alu_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   ALU_op;
  logic [5:0]   FuncCode;
  logic [W-1:0] A, B;
  logic         busy, done, Zero_Flag;
  logic [W-1:0] Output, HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_hi, m_lo, e_out;
  int           e_lat;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALU_op(ALU_op),
    .FuncCode(FuncCode), .A(A), .B(B), .busy(busy), .done(done),
    .Output(Output), .Zero_Flag(Zero_Flag), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: updates m_hi/m_lo and sets e_out/e_lat for one operation.
  task automatic model(input logic [1:0] op, input logic [5:0] fc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] prod;
    e_lat = 1;
    e_out = '0;
    if (op == 2'b00 || op == 2'b11) e_out = a + b;
    else if (op == 2'b01) e_out = a - b;
    else begin
      case (fc)
        6'h20: e_out = a + b;
        6'h22: e_out = a - b;
        6'h24: e_out = a & b;
        6'h25: e_out = a | b;
        6'h27: e_out = ~(a | b);
        6'h2a: e_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h10: e_out = m_hi;
        6'h12: e_out = m_lo;
        6'h19: begin
          prod  = {32'd0, a} * {32'd0, b};
          m_hi  = prod[63:32];
          m_lo  = prod[31:0];
          e_out = m_lo;
          e_lat = W;
        end
        6'h1b: begin
          if (b == 0) begin
            m_hi = a;
            m_lo = '1;
          end else begin
            m_hi  = a % b;
            m_lo  = a / b;
            e_lat = W;
          end
          e_out = m_lo;
        end
        default: e_out = '0;
      endcase
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [5:0] fc,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    model(op, fc, a, b);
    @(negedge clk);
    ALU_op = op; FuncCode = fc; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; B = $urandom; FuncCode = 6'($urandom);
    if (e_lat == 1) begin
      check("done_1cyc", {63'd0, done}, 64'd1);
      check("busy_1cyc", {63'd0, busy}, 64'd0);
    end else begin
      check("busy_start", {63'd0, busy}, 64'd1);
      n = 0;
      while (!done && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      check("latency", 64'(n), 64'(W));
      check("busy_end", {63'd0, busy}, 64'd0);
    end
    check("Output", {32'd0, Output}, {32'd0, e_out});
    check("Zero_Flag", {63'd0, Zero_Flag}, {63'd0, (e_out == 0)});
    check("HI", {32'd0, HI}, {32'd0, m_hi});
    check("LO", {32'd0, LO}, {32'd0, m_lo});
  endtask

  logic [5:0] fcs [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a,
                           6'h19, 6'h1b, 6'h10, 6'h12, 6'h3f};

  initial begin
    int dones, done_at;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    reset = 1'b1; start = 1'b0; ALU_op = 2'b10; FuncCode = '0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_out", {32'd0, Output}, 64'd0);
    check("rst_zf", {63'd0, Zero_Flag}, 64'd1);
    check("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk); reset = 1'b0;

    // Directed back-to-back single-cycle ops
    run_op(2'b10, 6'h20, 32'h10696671, 32'h12345678);
    check("add_val", {32'd0, Output}, 64'h229DBCE9);
    run_op(2'b10, 6'h22, 32'h10696671, 32'h12345678);
    check("sub_val", {32'd0, Output}, 64'hFE350FF9);
    run_op(2'b10, 6'h24, 32'h10696671, 32'h12345678);
    check("and_val", {32'd0, Output}, 64'h10204670);
    run_op(2'b10, 6'h2a, 32'h10696671, 32'h12345678);
    check("slt_val", {32'd0, Output}, 64'h1);
    run_op(2'b01, 6'h00, 32'h12345678, 32'h12345678);
    run_op(2'b10, 6'h3f, 32'h12345678, 32'h1);
    @(posedge clk); #1;
    check("done_drop", {63'd0, done}, 64'd0);

    run_op(2'b10, 6'h19, 32'd7, 32'd6);
    check("mul_small", {HI, LO}, 64'h2A);
    run_op(2'b10, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("mul_max", {HI, LO}, 64'hFFFFFFFE_00000001);
    run_op(2'b10, 6'h10, 32'd0, 32'd0);
    check("mfhi_val", {32'd0, Output}, 64'hFFFFFFFE);
    run_op(2'b10, 6'h1b, 32'd100, 32'd7);
    check("div_val", {HI, LO}, {32'd2, 32'd14});
    run_op(2'b10, 6'h1b, 32'd5, 32'd0);
    check("div0_val", {HI, LO}, {32'd5, 32'hFFFFFFFF});

    // start while busy must be ignored
    model(2'b10, 6'h1b, 32'd1000, 32'd7);
    @(negedge clk);
    ALU_op = 2'b10; FuncCode = 6'h1b; A = 32'd1000; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0; done_at = 0;
    for (int n = 1; n <= int'(W) + 4; n++) begin
      @(posedge clk); #1;
      if (done) begin dones++; done_at = n; end
      if (n == 5) begin ALU_op = 2'b00; A = 32'd1; B = 32'd2; start = 1'b1; end
      if (n == 6) begin start = 1'b0; ALU_op = 2'b10; end
    end
    check("busy_ign_dones", 64'(dones), 64'd1);
    check("busy_ign_at", 64'(done_at), 64'(W));
    check("busy_ign_out", {32'd0, Output}, {32'd0, e_out});
    check("busy_ign_hilo", {HI, LO}, {m_hi, m_lo});

    // reset mid-multu
    @(negedge clk);
    ALU_op = 2'b10; FuncCode = 6'h19; A = 32'd123; B = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    check("abort_out", {32'd0, Output}, 64'd0);
    check("abort_zf", {63'd0, Zero_Flag}, 64'd1);
    run_op(2'b10, 6'h19, 32'd3, 32'd5);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: ra = '1;
        2: rb = ra;
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      rop = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
      run_op(rop, fcs[$urandom_range(0, 10)], ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
